// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// Optional feature macro: BCD_AUTO_SAMPLE_EN (reconvert whenever bin_in changes, and once after reset).
module bin_to_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CMP_W = BIN_W + 64;
    localparam longint unsigned MAX_DEC = (64'd10 ** DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               start_eff;
    logic [3:0]         nib;

`ifdef BCD_AUTO_SAMPLE_EN
    logic [BIN_W-1:0]   last_q, last_d;
    logic               init_q, init_d;
    assign start_eff = start | init_q | (bin_in != last_q);
`else
    assign start_eff = start;
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        adj        = '0;
        nib        = '0;
`ifdef BCD_AUTO_SAMPLE_EN
        last_d     = last_q;
        init_d     = init_q;
`endif
        // Every nibble is corrected independently; no carry crosses nibbles.
        for (int i = 0; i < DIGITS; i++) begin
            nib = scratch_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end

        case (state_q)
            IDLE: begin
                if (start_eff) begin
                    state_d    = SHIFT;
                    shreg_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = CMP_W'(bin_in) > CMP_W'(MAX_DEC);
`ifdef BCD_AUTO_SAMPLE_EN
                    last_d     = bin_in;
                    init_d     = 1'b0;
`endif
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {adj[BCD_W-2:0], shreg_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = IDLE;
                    bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scratch_d;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef BCD_AUTO_SAMPLE_EN
            last_q     <= '0;
            init_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
`ifdef BCD_AUTO_SAMPLE_EN
            last_q     <= last_d;
            init_q     <= init_d;
`endif
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division, saturate above eight digits.
    function automatic logic [32:0] model(input logic [31:0] v);
        longint x;
        logic [31:0] r;
        x = longint'(v);
        r = '0;
        if (x > 64'd99999999) return {1'b1, 32'h99999999};
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic run_conv(input logic [31:0] v);
        logic [32:0] exp;
        logic [31:0] held;
        int bad;
        exp = model(v);
        bad = 0;
        @(negedge clk); start = 1'b1; bin_in = v;
        @(negedge clk); start = 1'b0; bin_in = $urandom;
        for (int c = 1; c <= 32; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_window v=%0d bad_cycles=%0d required 0", v, bad); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse v=%0d done=%b busy=%b required done=1 busy=0", v, done, busy); end
        checks++;
        if (bcd_out !== exp[31:0]) begin errors++; $display("FAIL bcd v=%0d got %h required %h", v, bcd_out, exp[31:0]); end
        checks++;
        if (ovf !== exp[32]) begin errors++; $display("FAIL ovf v=%0d got %b required %b", v, ovf, exp[32]); end
        held = exp[31:0];
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bcd_out !== held) begin errors++; $display("FAIL hold v=%0d done=%b bcd=%h required done=0 bcd=%h", v, done, bcd_out, held); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
        checks++;
        if (bcd_out !== 32'h0) begin errors++; $display("FAIL reset_bcd got %h required 00000000", bcd_out); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b required 0", ovf); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_conv(32'd0);
        run_conv(32'd12345678);
        run_conv(32'd99999999);
        run_conv(32'd100000000);
        run_conv(32'hFFFFFFFF);
        run_conv(32'd9);
        run_conv(32'd10);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int n = 0; n < 20; n++) begin
            case (n % 3)
                0: v = $urandom;
                1: v = $urandom_range(99999999, 0);
                default: v = $urandom_range(9999, 0);
            endcase
            run_conv(v);
        end
    endtask

    task automatic test_ignore_start();
        int bad;
        bad = 0;
        @(negedge clk); start = 1'b1; bin_in = 32'd255;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5) begin start = 1'b1; bin_in = 32'd7; end
            else if (c == 6) begin start = 1'b0; bin_in = $urandom; end
            if (done !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ignore_start_window bad_cycles=%0d required 0", bad); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bcd_out !== 32'h00000255) begin errors++; $display("FAIL ignore_start_result done=%b bcd=%h required 1 00000255", done, bcd_out); end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        // Still in the done cycle left by test_ignore_start.
        start = 1'b1; bin_in = 32'd7;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; bin_in = $urandom; end
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_window bad_cycles=%0d required 0", bad); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bcd_out !== 32'h00000007 || ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_result done=%b bcd=%h ovf=%b required 1 00000007 0", done, bcd_out, ovf);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        run_conv(32'd4321);
        @(negedge clk); start = 1'b1; bin_in = 32'd87654321;
        @(negedge clk); start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 32'h0 || ovf !== 1'b0) begin
            errors++; $display("FAIL abort_state busy=%b done=%b bcd=%h ovf=%b required 0 0 00000000 0", busy, done, bcd_out, ovf);
        end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL abort_no_done activity=%0d required 0", dones); end
        run_conv(32'd314159);
    endtask

`ifdef BCD_AUTO_SAMPLE_EN
    task automatic test_auto_sample();
        int dones;
        logic [31:0] got;
        reset = 1'b1; start = 1'b0; bin_in = 32'd42;
        @(negedge clk); reset = 1'b0;
        dones = 0; got = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; got = bcd_out; end
        end
        checks++;
        if (dones != 1 || got !== 32'h00000042) begin errors++; $display("FAIL auto_first dones=%0d bcd=%h required 1 00000042", dones, got); end
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL auto_hold dones=%0d required 0", dones); end
        bin_in = 32'd43;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; got = bcd_out; end
        end
        checks++;
        if (dones != 1 || got !== 32'h00000043) begin errors++; $display("FAIL auto_change dones=%0d bcd=%h required 1 00000043", dones, got); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BCD_AUTO_SAMPLE_EN
        test_auto_sample();
`else
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
